// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial ripple-borrow subtractor. An accepted start captures the
// operands, then one difference bit is produced per clock, LSB first, until
// all WIDTH bits are done. A one-cycle DONE state follows before the block
// returns to IDLE.
//
// Computes a - b - bin = diff - bout * 2^WIDTH (unsigned).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a subtraction (only honoured in IDLE)
//   a, b       minuend / subtrahend, captured on an accepted start
//   bin        borrow-in, captured on an accepted start
//   busy       high while in SHIFT or DONE
//   ser_bit    difference bit produced by the most recent SHIFT edge
//   ser_valid  high for the cycle following each SHIFT edge
//   diff       parallel difference; held until the next accepted start
//   bout       final borrow-out; held until the next accepted start
//   done       one-cycle completion pulse
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ser_bit;
    logic             r_ser_valid;

    logic             w_accept;
    logic             w_shift;
    logic             w_last;
    logic             w_d;
    logic             w_borrow_next;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_shift  = (r_state == S_SHIFT);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Full-subtractor cell on the current LSBs.
    assign w_d           = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_borrow_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:              w_state_next = S_IDLE;
            default:             w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs (driven purely from the state register)
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_SHIFT: busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_ser_bit   <= 1'b0;
            r_ser_valid <= 1'b0;
        end else begin
            // ser_valid is a single-cycle strobe behind each SHIFT edge.
            r_ser_valid <= 1'b0;
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_borrow <= bin;
                r_cnt    <= '0;
                r_diff   <= '0;
            end else if (w_shift) begin
                // Bits enter at the MSB end, so after WIDTH shifts the
                // first (LSB) bit has landed in diff[0].
                r_diff      <= {w_d, r_diff[WIDTH-1:1]};
                r_a         <= r_a >> 1;
                r_b         <= r_b >> 1;
                r_borrow    <= w_borrow_next;
                r_cnt       <= r_cnt + 1'b1;
                r_ser_bit   <= w_d;
                r_ser_valid <= 1'b1;
                if (w_last) begin
                    r_bout <= w_borrow_next;
                end
            end
        end
    end

    assign ser_bit   = r_ser_bit;
    assign ser_valid = r_ser_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Scoreboard bench for serial_subtractor (WIDTH = 8). The stimulus process
// pushes the arithmetically expected result for every accepted request; a
// monitor collects serial bits and, on each done pulse, pops and compares.
// ----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         ser_bit;
    logic         ser_valid;
    logic [W-1:0] diff;
    logic         bout;
    logic         done;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .busy      (busy),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .diff      (diff),
        .bout      (bout),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        int           acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: plain unsigned arithmetic in W+1 bits; the extra bit
    // of a negative result is the borrow-out.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mbin, input int acc);
        exp_t e;
        int   r;
        r = int'(ma) - int'(mb) - int'(mbin);
        e.a       = ma;
        e.b       = mb;
        e.bin     = mbin;
        e.diff    = W'(r & ((1 << W) - 1));
        e.bout    = (r < 0);
        e.acc_cyc = acc;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic [W-1:0] ser_acc;
    int           nbits = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            nbits = 0;
        end else begin
            if (ser_valid) begin
                if (nbits < W) ser_acc[nbits] = ser_bit;
                nbits++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("[TB] a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d (exp %02h/%0d) ser=%02h bits=%0d lat=%0d",
                             e.a, e.b, e.bin, diff, bout, e.diff, e.bout, ser_acc, nbits, cyc - e.acc_cyc);
                    check("diff", 32'(diff), 32'(e.diff));
                    check("bout", 32'(bout), 32'(e.bout));
                    check("ser_count", 32'(nbits), 32'(W));
                    check("ser_bits", 32'(ser_acc), 32'(e.diff));
                    check("latency", 32'(cyc - e.acc_cyc), 32'(W));
                end
                nbits = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Present a request for one edge; returns #1 after the accepting edge.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
        @(negedge clk);
        a     = ta;
        b     = tb_;
        bin   = tbin;
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(model(ta, tb_, tbin, cyc));
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_ser_bit"},   32'(ser_bit),   32'd0);
        check({tag, "_ser_valid"}, 32'(ser_valid), 32'd0);
        check({tag, "_diff"},      32'(diff),      32'd0);
        check({tag, "_bout"},      32'(bout),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int nb;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Basic subtraction, then results must hold while idle.
        do_op(8'h35, 8'h12, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);
        check("hold_diff", 32'(diff), 32'h23);
        check("hold_bout", 32'(bout), 32'd0);

        // Negative result; busy must be high for WIDTH+1 cycles.
        do_op(8'h12, 8'h35, 1'b0);
        nb = 0;
        @(negedge clk);
        while (busy && nb < 30) begin
            nb++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(nb), 32'(W + 1));

        // Borrow-in boundaries.
        do_op(8'h00, 8'h00, 1'b1);
        wait_idle();
        do_op(8'hFF, 8'hFF, 1'b0);
        wait_idle();

        // start during SHIFT must be ignored.
        do_op(8'h35, 8'h12, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a     = 8'h00;
        b     = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset after the 4th SHIFT edge aborts the operation.
        do_op(8'h35, 8'h12, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h80, 8'h01, 1'b0);
        wait_idle();

        // start held high: a new request every WIDTH+2 cycles.
        @(negedge clk);
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(model(a, b, bin, cyc));
        for (int k = 0; k < 5; k++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            bin = 1'($urandom);
            repeat (W + 2) @(posedge clk);
            #1;
            exp_q.push_back(model(a, b, bin, cyc));
        end
        start = 1'b0;
        wait_idle();

        // Random operations with random idle gaps.
        for (int k = 0; k < 30; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom));
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Drain.
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
